// File: rtl/ser_gpo_tx.sv
// ser_gpo_tx: serialises a parallel word MSB first onto a shift clock/data pair, then strobes an active-low latch.
module ser_gpo_tx #(
    parameter int WIDTH    = 8,
    parameter int SCK_HALF = 1
) (
    input  logic             serclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             ser_clk_out,
    output logic             ser_data_out,
    output logic             ser_load_out_n,
    output logic             busy,
    output logic             done
);
    localparam int TW = $clog2(SCK_HALF + 1);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic phase, done_r, half_end, bit_end, accept;
    assign half_end = timer == TW'(SCK_HALF - 1);
    assign bit_end = state == SHIFT && half_end && phase;
    assign accept = state == IDLE && p_valid;
    // phase selects the low (0) or high (1) half of the current bit
    always_ff @(posedge serclk) begin
        if (!reset_n) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            timer  <= '0;
            phase  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= state == LATCH && half_end;
            timer  <= (state == IDLE || half_end) ? '0 : timer + 1'b1;
            phase  <= state == SHIFT && (phase ^ half_end);
            if (accept) begin
                sr  <= p_in;
                cnt <= CW'(WIDTH - 1);
            end else if (bit_end) begin
                sr  <= {sr[WIDTH-2:0], 1'b0};
                cnt <= cnt - 1'b1;
            end
        end
    end
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = p_valid ? SHIFT : IDLE;
            SHIFT:   state_nxt = (bit_end && cnt == '0) ? LATCH : SHIFT;
            LATCH:   state_nxt = half_end ? IDLE : LATCH;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        p_ready        = state == IDLE;
        busy           = state != IDLE;
        ser_clk_out    = state == SHIFT && phase;
        ser_data_out   = state == SHIFT && sr[WIDTH-1];
        ser_load_out_n = state != LATCH;
        done           = done_r;
    end
endmodule
